// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: runs loads and stores against a data memory
// with variable acknowledge latency and drives a one-cycle register-file write pulse.
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_write_reg,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              err
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic              state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              dm_req_q,   dm_req_d;
  logic              dm_we_q,    dm_we_d;
  logic [DATA_W-1:0] dm_addr_q,  dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [REG_AW-1:0] dst_q,      dst_d;
  logic              ld_wb_q,    ld_wb_d;
  logic              rf_we_q,    rf_we_d;
  logic [REG_AW-1:0] rf_a3_q,    rf_a3_d;
  logic [DATA_W-1:0] rf_wd3_q,   rf_wd3_d;
  logic              err_q,      err_d;

  logic is_mem_op;
  logic is_illegal;
  logic dst_nonzero;

  assign is_mem_op   = ex_mem_read | ex_mem_write;
  assign is_illegal  = ex_mem_read & ex_mem_write;
  assign dst_nonzero = (ex_write_reg != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dst_d      = dst_q;
    ld_wb_d    = ld_wb_q;
    rf_we_d    = 1'b0;
    rf_a3_d    = rf_a3_q;
    rf_wd3_d   = rf_wd3_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (is_illegal) begin
            err_d = 1'b1;
          end else if (is_mem_op) begin
            state_d    = S_WAIT;
            cnt_d      = '0;
            dm_req_d   = 1'b1;
            dm_we_d    = ex_mem_write;
            dm_addr_d  = ex_alu_result;
            dm_wdata_d = ex_store_data;
            dst_d      = ex_write_reg;
            // Only a load with a real destination ever produces a write-back.
            ld_wb_d    = ex_mem_read & ex_reg_write & dst_nonzero;
          end else if (ex_reg_write && dst_nonzero) begin
            rf_we_d  = 1'b1;
            rf_a3_d  = ex_write_reg;
            rf_wd3_d = ex_alu_result;
          end
        end
      end

      S_WAIT: begin
        if (dm_ack) begin
          state_d  = S_IDLE;
          dm_req_d = 1'b0;
          if (ld_wb_q) begin
            rf_we_d  = 1'b1;
            rf_a3_d  = dst_q;
            rf_wd3_d = dm_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_IDLE;
          dm_req_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dst_q      <= '0;
      ld_wb_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_a3_q    <= '0;
      rf_wd3_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dst_q      <= dst_d;
      ld_wb_q    <= ld_wb_d;
      rf_we_q    <= rf_we_d;
      rf_a3_q    <= rf_a3_d;
      rf_wd3_q   <= rf_wd3_d;
      err_q      <= err_d;
    end
  end

  assign stall    = (state_q == S_WAIT);
  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign rf_we    = rf_we_q;
  assign rf_a3    = rf_a3_q;
  assign rf_wd3   = rf_wd3_q;
  assign err      = err_q;

endmodule
